ebpc_out_packer: RTL and testbench

//  Downstream stage of ebpc_decoder: packs the decoder's DATA_W-bit decompressed element stream into
//  OUT_W-bit words for the DMA/memory write path. Each packet is framed by an expected element count
//  on a side handshake channel, which is the same count fed to the decoder's num_words input.
//  The block checks the decoder's element count against it, marks the final word with last_o and

---
 rtl/ebpc_out_packer_if.sv | 33 +++
 rtl/ebpc_out_packer.sv | 166 ++++++++++++++++
 tb/tb_ebpc_out_packer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebpc_out_packer_if.sv
// Port bundle for ebpc_out_packer: length side channel, element input stream, packed word output.
// The slave modport is the packer; master is whoever drives lengths/elements and consumes words.
interface ebpc_out_packer_if #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned LOG_MAX_WORDS = 24
);
    localparam int unsigned LANES = OUT_W / DATA_W;

    logic [LOG_MAX_WORDS-1:0] num_words;
    logic                     num_words_vld;
    logic                     num_words_rdy;
    logic [DATA_W-1:0]        in_data;
    logic                     in_last;
    logic                     in_vld;
    logic                     in_rdy;
    logic [OUT_W-1:0]         out_data;
    logic [LANES-1:0]         out_keep;
    logic                     out_last;
    logic                     out_vld;
    logic                     out_rdy;
    logic                     len_err;

    modport master (
        output num_words, num_words_vld, in_data, in_last, in_vld, out_rdy,
        input  num_words_rdy, in_rdy, out_data, out_keep, out_last, out_vld, len_err
    );

    modport slave (
        input  num_words, num_words_vld, in_data, in_last, in_vld, out_rdy,
        output num_words_rdy, in_rdy, out_data, out_keep, out_last, out_vld, len_err
    );
endinterface

// File: rtl/ebpc_out_packer.sv
// Packs decoder elements into OUT_W-bit words, framing each packet by an expected element count
// and flagging (sticky) any count/last mismatch.
module ebpc_out_packer #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned LOG_MAX_WORDS = 24
) (
    input logic               clk_i,
    input logic               rst_i,
    ebpc_out_packer_if.slave  bus
);
    localparam int unsigned LANES  = OUT_W / DATA_W;
    localparam int unsigned LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {StWaitLen, StCollect, StDrop} state_e;

    state_e                   state_q, state_d;
    logic [LOG_MAX_WORDS-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [OUT_W-1:0]         acc_q, acc_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic                     closed_q, closed_d;
    logic [LANES-1:0]         ckeep_q, ckeep_d;
    logic                     clast_q, clast_d;
    logic [OUT_W-1:0]         odata_q, odata_d;
    logic [LANES-1:0]         okeep_q, okeep_d;
    logic                     olast_q, olast_d;
    logic                     ovld_q, ovld_d;
    logic                     err_q, err_d;

    logic              oreg_free, acc_blocked, move_acc, take, pkt_end, closing;
    logic [LANE_W-1:0] base_lane;
    logic [OUT_W-1:0]  new_acc;
    logic [LANES-1:0]  new_keep;

    always_comb begin
        oreg_free   = !ovld_q || bus.out_rdy;
        acc_blocked = closed_q && !oreg_free;
        bus.num_words_rdy = !rst_i && (state_q == StWaitLen) && !acc_blocked;
        bus.in_rdy = !rst_i && (((state_q == StCollect) && !acc_blocked) || (state_q == StDrop));
        take      = bus.in_vld && bus.in_rdy && (state_q == StCollect);
        // A pending closed word leaving this edge frees the accumulator for the incoming element.
        move_acc  = closed_q && oreg_free;
        base_lane = move_acc ? '0 : lane_q;
        pkt_end   = take && ((cnt_q == n_q) || bus.in_last);
        closing   = take && ((base_lane == LANE_W'(LANES - 1)) || pkt_end);
        new_acc   = move_acc ? '0 : acc_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            new_keep[i] = (LANE_W'(i) <= base_lane);
            if (LANE_W'(i) == base_lane) begin
                new_acc[i*DATA_W +: DATA_W] = bus.in_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lane_d   = lane_q;
        closed_d = closed_q;
        ckeep_d  = ckeep_q;
        clast_d  = clast_q;
        odata_d  = odata_q;
        okeep_d  = okeep_q;
        olast_d  = olast_q;
        ovld_d   = ovld_q && !bus.out_rdy;
        err_d    = err_q;

        if (move_acc) begin
            odata_d  = acc_q;
            okeep_d  = ckeep_q;
            olast_d  = clast_q;
            ovld_d   = 1'b1;
            acc_d    = '0;
            lane_d   = '0;
            closed_d = 1'b0;
        end

        if (take) begin
            cnt_d = cnt_q + LOG_MAX_WORDS'(1);
            if (closing && oreg_free && !move_acc) begin
                odata_d = new_acc;
                okeep_d = new_keep;
                olast_d = pkt_end;
                ovld_d  = 1'b1;
                acc_d   = '0;
                lane_d  = '0;
            end else if (closing) begin
                acc_d    = new_acc;
                lane_d   = '0;
                closed_d = 1'b1;
                ckeep_d  = new_keep;
                clast_d  = pkt_end;
            end else begin
                acc_d  = new_acc;
                lane_d = base_lane + LANE_W'(1);
            end
        end

        unique case (state_q)
            StWaitLen: begin
                if (bus.num_words_vld && bus.num_words_rdy) begin
                    n_d     = bus.num_words;
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (pkt_end) begin
                    if (cnt_q == n_q && bus.in_last) begin
                        state_d = StWaitLen;
                    end else if (cnt_q == n_q) begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StWaitLen;
                    end
                end
            end
            StDrop: begin
                if (bus.in_vld && bus.in_last) state_d = StWaitLen;
            end
            default: state_d = StWaitLen;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StWaitLen;
            n_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lane_q   <= '0;
            closed_q <= 1'b0;
            ckeep_q  <= '0;
            clast_q  <= 1'b0;
            odata_q  <= '0;
            okeep_q  <= '0;
            olast_q  <= 1'b0;
            ovld_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lane_q   <= lane_d;
            closed_q <= closed_d;
            ckeep_q  <= ckeep_d;
            clast_q  <= clast_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            olast_q  <= olast_d;
            ovld_q   <= ovld_d;
            err_q    <= err_d;
        end
    end

    assign bus.out_data = odata_q;
    assign bus.out_keep = okeep_q;
    assign bus.out_last = olast_q;
    assign bus.out_vld  = ovld_q;
    assign bus.len_err  = err_q;
endmodule

// File: tb/tb_ebpc_out_packer.sv
// Directed and randomized bench for ebpc_out_packer; expected words come from a chunking model
// over the element list of each packet.
module tb_ebpc_out_packer;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned LOG_MAX_WORDS = 24;
    localparam int unsigned LANES = OUT_W / DATA_W;
    localparam int unsigned LIMIT = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ebpc_out_packer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .LOG_MAX_WORDS(LOG_MAX_WORDS)) bus ();
    ebpc_out_packer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .LOG_MAX_WORDS(LOG_MAX_WORDS)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit abort = 1'b0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned pk_n[$];
    int unsigned pk_len[$];
    logic [DATA_W-1:0] el[$];
    logic [OUT_W-1:0] ex_data[$];
    logic [LANES-1:0] ex_keep[$];
    bit ex_last[$];
    int unsigned word_cyc[$];
    bit exp_err = 1'b0;
    int unsigned vmax = 0;
    int unsigned rmax = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        abort = 1'b1;
        $error("FAIL %s: observed timeout expected handshake within %0d cycles", tag, LIMIT);
    endtask

    task automatic add_pkt(input int unsigned n, input int unsigned len, input int unsigned first);
        pk_n.push_back(n);
        pk_len.push_back(len);
        for (int unsigned i = 0; i < len; i++) el.push_back(DATA_W'(first + i));
    endtask

    // Each packet yields its first min(len, N+1) elements, LANES per word, zero-padded at the end.
    task automatic model_all();
        int unsigned base = 0;
        for (int p = 0; p < pk_n.size(); p++) begin
            int unsigned k;
            k = (pk_len[p] < pk_n[p] + 1) ? pk_len[p] : pk_n[p] + 1;
            if (pk_len[p] != pk_n[p] + 1) exp_err = 1'b1;
            for (int unsigned w = 0; w * LANES < k; w++) begin
                logic [OUT_W-1:0] d;
                logic [LANES-1:0] kp;
                d = '0;
                kp = '0;
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (w * LANES + j < k) begin
                        d[j*DATA_W +: DATA_W] = el[base + w * LANES + j];
                        kp[j] = 1'b1;
                    end
                end
                ex_data.push_back(d);
                ex_keep.push_back(kp);
                ex_last.push_back((w + 1) * LANES >= k);
            end
            base += pk_len[p];
        end
    endtask

    task automatic send_len(input int unsigned n);
        int unsigned t = 0;
        bus.num_words = LOG_MAX_WORDS'(n);
        bus.num_words_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.num_words_rdy) break;
            if (++t > LIMIT) begin
                timeout("len_handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.num_words_vld = 1'b0;
    endtask

    task automatic send_elem(input logic [DATA_W-1:0] d, input bit last);
        int unsigned t = 0;
        int unsigned st;
        st = $urandom_range(0, vmax);
        if (st > 0) begin
            bus.in_vld = 1'b0;
            repeat (st) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_data = d;
        bus.in_last = last;
        bus.in_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_rdy) break;
            if (++t > LIMIT) begin
                timeout("elem_handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic produce();
        int unsigned base = 0;
        for (int p = 0; p < pk_n.size() && !abort; p++) begin
            send_len(pk_n[p]);
            for (int unsigned i = 0; i < pk_len[p] && !abort; i++)
                send_elem(el[base + i], i == pk_len[p] - 1);
            base += pk_len[p];
        end
        bus.in_vld = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic consume(input int unsigned cnt);
        for (int unsigned w = 0; w < cnt && !abort; w++) begin
            int unsigned st;
            int unsigned t = 0;
            st = $urandom_range(0, rmax);
            bus.out_rdy = 1'b0;
            repeat (st) begin
                @(negedge clk);
                if (bus.out_vld) check("stall_data", bus.out_data, ex_data[0]);
                @(posedge clk);
                #1;
            end
            bus.out_rdy = 1'b1;
            forever begin
                @(negedge clk);
                if (bus.out_vld) break;
                if (++t > LIMIT) begin
                    timeout("out_valid");
                    break;
                end
            end
            if (abort) break;
            check("data", bus.out_data, ex_data.pop_front());
            check("keep", bus.out_keep, ex_keep.pop_front());
            check("last", bus.out_last, ex_last.pop_front());
            word_cyc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        bus.out_rdy = 1'b0;
    endtask

    task automatic run();
        int unsigned cnt;
        ex_data.delete();
        ex_keep.delete();
        ex_last.delete();
        word_cyc.delete();
        model_all();
        cnt = ex_data.size();
        fork
            produce();
            consume(cnt);
        join
        repeat (3) @(posedge clk);
        #1;
        check("no_extra_word", bus.out_vld, 1'b0);
        check("len_err", bus.len_err, exp_err);
        pk_n.delete();
        pk_len.delete();
        el.delete();
    endtask

    initial begin
        bus.num_words = '0;
        bus.num_words_vld = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", bus.out_vld, 1'b0);
        check("rst_err", bus.len_err, 1'b0);
        check("rst_keep", bus.out_keep, '0);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_data", bus.out_data, '0);
        check("rst_len_rdy", bus.num_words_rdy, 1'b0);
        check("rst_in_rdy", bus.in_rdy, 1'b0);
        rst = 1'b0;
        #1;
        check("idle_len_rdy", bus.num_words_rdy, 1'b1);
        check("idle_in_rdy", bus.in_rdy, 1'b0);

        // 1: two full words, no bubbles
        add_pkt(7, 8, 8'h01);
        run();
        if (word_cyc.size() == 2) check("no_bubble_gap", word_cyc[1] - word_cyc[0], 4);

        // 2: partial final word; 3: short packet, then a single-element packet
        add_pkt(4, 5, 8'hA0);
        run();
        add_pkt(5, 3, 8'h11);
        el[0] = 8'h11;
        el[1] = 8'h22;
        el[2] = 8'h33;
        add_pkt(0, 1, 8'h55);
        run();
        // full-width count must not be truncated
        add_pkt((1 << LOG_MAX_WORDS) - 1, 2, 8'hC0);
        run();

        // 4: too long, tail dropped
        add_pkt(1, 4, 8'hD0);
        run();

        // 6: reset with OREG full and stalled
        bus.out_rdy = 1'b0;
        send_len(7);
        for (int unsigned i = 0; i < 6 && !abort; i++) send_elem(DATA_W'(8'h61 + i), 1'b0);
        bus.in_vld = 1'b0;
        #1;
        check("pre_rst_vld", bus.out_vld, 1'b1);
        check("pre_rst_data", bus.out_data, 32'h64636261);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_vld", bus.out_vld, 1'b0);
        check("mid_rst_err", bus.len_err, 1'b0);
        check("mid_rst_in_rdy", bus.in_rdy, 1'b0);
        rst = 1'b0;
        exp_err = 1'b0;
        add_pkt(2, 3, 8'hE1);
        run();

        // 5: random stalls on both sides, well-formed packets
        vmax = 3;
        rmax = 3;
        for (int p = 0; p < 80; p++) begin
            int unsigned n;
            n = (p < 8) ? $urandom_range(0, 5) : $urandom_range(0, 300);
            pk_n.push_back(n);
            pk_len.push_back(n + 1);
            for (int unsigned i = 0; i <= n; i++) el.push_back(DATA_W'($urandom));
        end
        if (!abort) run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
